// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-access FSM state encoding and default timeout.
package cpu_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 4;

  typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// RAM-side request/response bus of the memory access unit.
interface mem_access_unit_if #(parameter int ADDR_W = 9) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (output mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/reg32.sv
// 32-bit load-enable register with synchronous active-high clear.
module reg32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR pair plus a handshake FSM that issues one RAM read or write at a time
// and aborts with an err pulse if the RAM does not acknowledge within TIMEOUT cycles.
module mem_access_unit import cpu_pkg::*; #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic  clk,
  input  logic  clr,
  input  word_t bus_in,
  input  logic  MARin,
  input  logic  MDRin,
  input  logic  mem_read,
  input  logic  mem_write,
  output word_t MDR_out,
  output logic  busy,
  output logic  done,
  output logic  err,
  mem_access_unit_if.master mem
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  word_t            mar_q, mdr_d;
  logic             mar_ld, mdr_ld, idle, rd_wait;

  assign idle    = (state == ST_IDLE);
  assign rd_wait = (state == ST_RD_WAIT);

  // MAR/MDR only accept bus loads while idle; read data lands in MDR on the ack edge.
  assign mar_ld = idle && MARin;
  assign mdr_ld = (idle && MDRin) || (rd_wait && mem.mem_ack);
  assign mdr_d  = rd_wait ? mem.mem_rdata : bus_in;

  reg32 u_mar (.clk(clk), .clr(clr), .en(mar_ld),
               .d({{(32-ADDR_W){1'b0}}, bus_in[ADDR_W-1:0]}), .q(mar_q));
  reg32 u_mdr (.clk(clk), .clr(clr), .en(mdr_ld), .d(mdr_d), .q(MDR_out));

  logic unused_mar_hi;
  assign unused_mar_hi = ^mar_q[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (mem_read)       state <= ST_RD_WAIT;
          else if (mem_write) state <= ST_WR_WAIT;
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          // Ack is checked first so a late ack on the final wait cycle still succeeds.
          if (mem.mem_ack) begin
            state <= ST_FINISH;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = !idle;
  assign done          = (state == ST_FINISH);
  assign err           = err_q;
  assign mem.mem_addr  = mar_q[ADDR_W-1:0];
  assign mem.mem_wdata = MDR_out;
  assign mem.mem_rd_en = rd_wait;
  assign mem.mem_wr_en = (state == ST_WR_WAIT);
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scenario tasks with a queue of expected results.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus_in;
  logic        MARin, MDRin, mem_read, mem_write;
  logic [31:0] MDR_out;
  logic        busy, done, err;

  mem_access_unit_if #(.ADDR_W(9)) m ();

  mem_access_unit #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
    .mem_read(mem_read), .mem_write(mem_write), .MDR_out(MDR_out),
    .busy(busy), .done(done), .err(err), .mem(m)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n_done;
    int          n_err;
    int          n_rd;
    int          n_wr;
    int          lat;
    logic [31:0] mdr;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access, answers it with an ack on wait cycle ack_after (-1 = never)
  // and records what the DUT did until it is idle again.
  task automatic run_txn(input bit rd, input bit wr, input int ack_after,
                         input logic [31:0] rdata, input bit spoil,
                         output exp_t obs);
    bit seen = 1'b0;
    obs.n_done = 0; obs.n_err = 0; obs.n_rd = 0; obs.n_wr = 0; obs.lat = -1;
    obs.mdr = '0; obs.addr = '0; obs.wdata = '0;
    mem_read = rd; mem_write = wr;
    tick();
    mem_read = 0; mem_write = 0; MARin = 0; MDRin = 0;
    for (int k = 0; k < 40; k++) begin
      if (m.mem_rd_en) begin obs.n_rd++; obs.addr = m.mem_addr; end
      if (m.mem_wr_en) begin obs.n_wr++; obs.addr = m.mem_addr; obs.wdata = m.mem_wdata; end
      if (done || err) begin
        if (done) obs.n_done++;
        if (err)  obs.n_err++;
        if (!seen) begin obs.lat = k; obs.mdr = MDR_out; end
        seen = 1'b1;
      end else if (seen && !busy) begin
        break;
      end
      m.mem_ack   = (k == ack_after);
      m.mem_rdata = rdata;
      if (spoil && busy) begin
        MDRin = 1; MARin = 1; mem_read = 1; bus_in = 32'hFFFF_FFFF;
      end else begin
        MDRin = 0; MARin = 0; mem_read = 0;
      end
      tick();
    end
    m.mem_ack = 0; MDRin = 0; MARin = 0; mem_read = 0; bus_in = '0;
  endtask

  task automatic test_reset();
    clr = 1; bus_in = 32'h1AB; MARin = 1; MDRin = 1; mem_read = 1; mem_write = 1;
    m.mem_ack = 1; m.mem_rdata = 32'h5555_5555;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
    n_cmp++; if (m.mem_rd_en !== 1'b0 || m.mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: got %b%b want 00", m.mem_rd_en, m.mem_wr_en); end
    n_cmp++; if (MDR_out !== 32'h0) begin n_bad++; $display("FAIL reset_mdr: got %h want 0", MDR_out); end
    n_cmp++; if (m.mem_addr !== 9'h0) begin n_bad++; $display("FAIL reset_mar: got %h want 0", m.mem_addr); end
    clr = 0; MARin = 0; MDRin = 0; mem_read = 0; mem_write = 0; m.mem_ack = 0; bus_in = '0;
    tick();
  endtask

  task automatic test_read();
    exp_t obs, e;
    bus_in = 32'h005; MARin = 1; tick(); MARin = 0;
    sb.push_back('{n_done:1, n_err:0, n_rd:3, n_wr:0, lat:3, mdr:32'hDEAD_BEEF, addr:9'h005, wdata:'0});
    run_txn(1, 0, 2, 32'hDEAD_BEEF, 0, obs);
    e = sb.pop_front();
    n_cmp++; if (obs.n_done !== e.n_done || obs.n_err !== e.n_err) begin n_bad++; $display("FAIL read_pulses: got done=%0d err=%0d want done=%0d err=%0d", obs.n_done, obs.n_err, e.n_done, e.n_err); end
    n_cmp++; if (obs.mdr !== e.mdr) begin n_bad++; $display("FAIL read_mdr: got %h want %h", obs.mdr, e.mdr); end
    n_cmp++; if (obs.addr !== e.addr) begin n_bad++; $display("FAIL read_addr: got %h want %h", obs.addr, e.addr); end
    n_cmp++; if (obs.lat !== e.lat || obs.n_rd !== e.n_rd) begin n_bad++; $display("FAIL read_timing: got lat=%0d rd=%0d want lat=%0d rd=%0d", obs.lat, obs.n_rd, e.lat, e.n_rd); end
  endtask

  task automatic test_write();
    exp_t obs, e;
    bus_in = 32'h1234_5678; MDRin = 1; tick(); MDRin = 0;
    // MAR load in the same cycle as the write strobe
    bus_in = 32'h0000_01FF; MARin = 1;
    sb.push_back('{n_done:1, n_err:0, n_rd:0, n_wr:1, lat:1, mdr:32'h1234_5678, addr:9'h1FF, wdata:32'h1234_5678});
    run_txn(0, 1, 0, 32'h0, 0, obs);
    e = sb.pop_front();
    n_cmp++; if (obs.n_wr !== e.n_wr || obs.n_rd !== e.n_rd) begin n_bad++; $display("FAIL write_strobes: got wr=%0d rd=%0d want wr=%0d rd=%0d", obs.n_wr, obs.n_rd, e.n_wr, e.n_rd); end
    n_cmp++; if (obs.wdata !== e.wdata || obs.addr !== e.addr) begin n_bad++; $display("FAIL write_bus: got %h@%h want %h@%h", obs.wdata, obs.addr, e.wdata, e.addr); end
    n_cmp++; if (obs.lat !== e.lat || obs.n_done !== e.n_done) begin n_bad++; $display("FAIL write_done: got lat=%0d done=%0d want lat=%0d done=%0d", obs.lat, obs.n_done, e.lat, e.n_done); end
    // MDR load in the same cycle as the write strobe
    bus_in = 32'hA5A5_A5A5; MDRin = 1;
    sb.push_back('{n_done:1, n_err:0, n_rd:0, n_wr:1, lat:1, mdr:32'hA5A5_A5A5, addr:9'h1FF, wdata:32'hA5A5_A5A5});
    run_txn(0, 1, 0, 32'h0, 0, obs);
    e = sb.pop_front();
    n_cmp++; if (obs.wdata !== e.wdata || obs.addr !== e.addr) begin n_bad++; $display("FAIL write_newdata: got %h@%h want %h@%h", obs.wdata, obs.addr, e.wdata, e.addr); end
  endtask

  task automatic test_timeout();
    exp_t obs, e;
    sb.push_back('{n_done:0, n_err:1, n_rd:15, n_wr:0, lat:15, mdr:32'hA5A5_A5A5, addr:9'h1FF, wdata:'0});
    run_txn(1, 0, -1, 32'h9999_9999, 0, obs);
    e = sb.pop_front();
    n_cmp++; if (obs.n_err !== e.n_err || obs.n_done !== e.n_done) begin n_bad++; $display("FAIL timeout_pulses: got err=%0d done=%0d want err=%0d done=%0d", obs.n_err, obs.n_done, e.n_err, e.n_done); end
    n_cmp++; if (obs.lat !== e.lat || obs.n_rd !== e.n_rd) begin n_bad++; $display("FAIL timeout_timing: got lat=%0d rd=%0d want lat=%0d rd=%0d", obs.lat, obs.n_rd, e.lat, e.n_rd); end
    n_cmp++; if (obs.mdr !== e.mdr || MDR_out !== e.mdr) begin n_bad++; $display("FAIL timeout_mdr: got %h want %h", MDR_out, e.mdr); end
    n_cmp++; if (m.mem_rd_en !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: got rd_en=%b busy=%b want 0 0", m.mem_rd_en, busy); end
  endtask

  task automatic test_both_strobes();
    exp_t obs, e;
    bus_in = 32'h033; MARin = 1; tick(); MARin = 0;
    sb.push_back('{n_done:1, n_err:0, n_rd:2, n_wr:0, lat:2, mdr:32'hCAFE_F00D, addr:9'h033, wdata:'0});
    run_txn(1, 1, 1, 32'hCAFE_F00D, 1, obs);
    e = sb.pop_front();
    n_cmp++; if (obs.n_rd !== e.n_rd || obs.n_wr !== e.n_wr) begin n_bad++; $display("FAIL both_priority: got rd=%0d wr=%0d want rd=%0d wr=%0d", obs.n_rd, obs.n_wr, e.n_rd, e.n_wr); end
    n_cmp++; if (obs.mdr !== e.mdr || MDR_out !== e.mdr) begin n_bad++; $display("FAIL busy_mdrin: got %h want %h", MDR_out, e.mdr); end
    n_cmp++; if (m.mem_addr !== e.addr || obs.n_done !== e.n_done) begin n_bad++; $display("FAIL busy_marin: got %h done=%0d want %h done=%0d", m.mem_addr, obs.n_done, e.addr, e.n_done); end
  endtask

  task automatic test_ack_boundary();
    exp_t obs, e;
    sb.push_back('{n_done:1, n_err:0, n_rd:15, n_wr:0, lat:15, mdr:32'h0BAD_CAFE, addr:9'h033, wdata:'0});
    run_txn(1, 0, 14, 32'h0BAD_CAFE, 0, obs);
    e = sb.pop_front();
    n_cmp++; if (obs.n_done !== e.n_done || obs.n_err !== e.n_err) begin n_bad++; $display("FAIL ack_last_cycle: got done=%0d err=%0d want done=%0d err=%0d", obs.n_done, obs.n_err, e.n_done, e.n_err); end
    n_cmp++; if (obs.mdr !== e.mdr || obs.lat !== e.lat) begin n_bad++; $display("FAIL ack_last_data: got %h lat=%0d want %h lat=%0d", obs.mdr, obs.lat, e.mdr, e.lat); end
  endtask

  task automatic test_clr_mid();
    int n_done = 0;
    bus_in = 32'h044; MARin = 1; tick(); MARin = 0;
    mem_read = 1; tick(); mem_read = 0;
    tick();
    clr = 1; tick(); clr = 0;
    n_cmp++; if (busy !== 1'b0 || m.mem_rd_en !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL clr_mid_ctrl: got busy=%b rd=%b done=%b err=%b want 0000", busy, m.mem_rd_en, done, err); end
    n_cmp++; if (MDR_out !== 32'h0 || m.mem_addr !== 9'h0) begin n_bad++; $display("FAIL clr_mid_regs: got %h@%h want 0@0", MDR_out, m.mem_addr); end
    m.mem_ack = 1; m.mem_rdata = 32'h1111_2222; tick(); m.mem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || err || busy) n_done++;
      tick();
    end
    n_cmp++; if (n_done !== 0 || MDR_out !== 32'h0) begin n_bad++; $display("FAIL clr_late_ack: got activity=%0d mdr=%h want 0 0", n_done, MDR_out); end
  endtask

  task automatic test_ack_idle();
    bus_in = 32'h7777_0000; MDRin = 1; tick(); MDRin = 0; bus_in = '0;
    m.mem_ack = 1; m.mem_rdata = 32'h3333_4444; tick(); m.mem_ack = 0;
    tick();
    n_cmp++; if (MDR_out !== 32'h7777_0000 || done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_ack: got mdr=%h done=%b busy=%b want 77770000 0 0", MDR_out, done, busy); end
  endtask

  initial begin
    clr = 1; bus_in = '0; MARin = 0; MDRin = 0; mem_read = 0; mem_write = 0;
    m.mem_ack = 0; m.mem_rdata = '0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_both_strobes();
    test_ack_boundary();
    test_clr_mid();
    test_ack_idle();
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 9, memory word-address width (512-word RAM).
REQ-002 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ack before abort.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 clr  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 bus_in  input  32  datapath bus value (BUS_data).
REQ-006 MARin  input  1  load MAR from bus_in[ADDR_W-1:0].
REQ-007 MDRin  input  1  load MDR from bus_in (ignored while busy).
REQ-008 mem_read  input  1  one-cycle strobe: start read at MAR; result into MDR.
REQ-009 mem_write  input  1  one-cycle strobe: start write of MDR to MAR.
REQ-010 MDR_out  output  32  MDR contents, drives the bus mux MDR input.
REQ-011 mem_addr  output  ADDR_W  address to RAM, equal to MAR.
REQ-012 mem_wdata  output  32  write data to RAM, equal to MDR.
REQ-013 mem_rd_en / mem_wr_en  output  1 each  RAM request strobes, held until ack or abort.
REQ-014 mem_rdata  input  32  RAM read data, valid in the cycle mem_ack is high.
REQ-015 mem_ack  input  1  RAM completion, one cycle.
REQ-016 busy  output  1  high from the cycle after the start strobe until return to IDLE.
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-019 The FSM SHALL have states IDLE, RD_WAIT, WR_WAIT, FINISH.
REQ-020 IDLE: mem_read -> RD_WAIT; else mem_write -> WR_WAIT; both high SHALL give read priority; MARin/MDRin SHALL load in IDLE.
REQ-021 RD_WAIT/WR_WAIT SHALL assert mem_rd_en/mem_wr_en respectively; mem_ack -> FINISH with done pulse in FINISH.
REQ-022 In RD_WAIT, when mem_ack is high, MDR SHALL capture mem_rdata on that edge; MDR_out reflects it the following cycle.
REQ-023 Minimum latency: start strobe at edge N, ack sampled at N+1, done high in cycle N+2, busy low from N+3.
REQ-024 A 4-bit wait counter SHALL clear on entry to a WAIT state and increment each cycle without ack; reaching TIMEOUT without ack SHALL return to IDLE, pulse err, leave MDR unchanged, deassert strobes.
REQ-025 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-026 FINISH SHALL last exactly one cycle then return to IDLE.
REQ-027 mem_read/mem_write/MARin/MDRin while busy SHALL be ignored (no queuing).
REQ-028 mem_ack in IDLE or FINISH SHALL be ignored.
REQ-029 MARin and a start strobe in the same IDLE cycle: access SHALL use the newly loaded address.
REQ-030 MDRin and mem_write in the same IDLE cycle: write SHALL use the newly loaded data.

Reset
REQ-031 clr SHALL force IDLE, MAR=0, MDR=0, counter=0, busy=done=err=mem_rd_en=mem_wr_en=0 at the next edge.
REQ-032 clr mid-transaction SHALL abort without done/err; a late mem_ack afterwards SHALL be ignored.
REQ-033 clr SHALL take priority over every other input in the same cycle.

Structure
REQ-034 State encoding and the TIMEOUT default SHALL live in shared package cpu_pkg.
REQ-035 MAR and MDR SHALL reuse the team's existing 32-bit register sub-module (reg32), MAR truncated to ADDR_W; FSM inline.

Verification
REQ-036 Read: MARin with bus_in=0x005, mem_read, ack after 2 cycles with rdata=0xDEADBEEF -> mem_addr=0x005, MDR_out=0xDEADBEEF, one done pulse.
REQ-037 Write: MDRin 0x12345678, MARin 0x1FF, mem_write, immediate ack -> mem_wr_en 1 cycle, mem_wdata=0x12345678, done at N+2.
REQ-038 Timeout: mem_read, no ack -> err pulse after 15 wait cycles, MDR unchanged, strobes low.
REQ-039 Both strobes together -> read only; MDRin 0xFFFFFFFF while busy -> MDR holds read data.
REQ-040 clr during RD_WAIT, then ack -> all outputs 0, no done, MDR=0.
REQ-041 Ack on the 15th wait cycle -> done, no err.
